// File: rtl/jt5205_interp_arb_if.sv
// Channel-side bundle for the jt5205 interpolation arbiter: strobes and samples in,
// interpolated lanes, valid pulses, status and mix out.
interface jt5205_interp_arb_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 12
);
    logic [NCH-1:0]   cen_mid;
    logic [W*NCH-1:0] din;
    logic [W*NCH-1:0] dout;
    logic [NCH-1:0]   dout_valid;
    logic             busy;
    logic [NCH-1:0]   overrun;
    logic [W-1:0]     mix;

    modport master (
        output cen_mid, din,
        input  dout, dout_valid, busy, overrun, mix
    );

    modport slave (
        input  cen_mid, din,
        output dout, dout_valid, busy, overrun, mix
    );
endinterface

// File: rtl/jt5205_interp_arb.sv
// Round-robin 2x interpolation scheduler sharing one half-sum datapath across NCH channels.
// Optional saturated lane mixer enabled by defining JT5205_ARB_MIX_EN.
module jt5205_interp_arb #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 12
) (
    input logic                clk,
    input logic                rst,
    jt5205_interp_arb_if.slave bus
);
    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e              state_q, state_d;
    logic [NCH-1:0]      pending_q, pending_d, clr;
    logic [NCH-1:0]      overrun_q, valid_q;
    logic [PW-1:0]       ptr_q, gnt_q, idx;
    logic                grant, found;
    int unsigned         j;
    logic signed [W-1:0] smp_q [NCH];
    logic signed [W-1:0] last_q [NCH];
    logic signed [W-1:0] op_q, hist_q, half_sum;
    logic [W*NCH-1:0]    dout_q;

    // First pending channel at or after ptr, wrapping around.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NCH; k++) begin
            j = 32'(ptr_q) + 32'(k);
            if (j >= NCH) j = j - NCH;
            if (!found && pending_q[j[PW-1:0]]) begin
                found = 1'b1;
                idx   = j[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    grant   = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        clr = '0;
        if (grant) clr[idx] = 1'b1;
        // A new strobe wins over the grant clearing the same channel.
        pending_d = (pending_q & ~clr) | bus.cen_mid;
    end

    assign half_sum = (hist_q >>> 1) + (op_q >>> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
            valid_q   <= '0;
            dout_q    <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            op_q      <= '0;
            hist_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                smp_q[i]  <= '0;
                last_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_q | (bus.cen_mid & pending_q & ~clr);
            valid_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (bus.cen_mid[i]) smp_q[i] <= bus.din[i*W +: W];
            end
            if (grant) begin
                gnt_q  <= idx;
                op_q   <= smp_q[idx];
                hist_q <= last_q[idx];
            end
            if (state_q == StCalc) begin
                dout_q[gnt_q*W +: W] <= half_sum;
                last_q[gnt_q]        <= op_q;
                valid_q[gnt_q]       <= 1'b1;
                ptr_q                <= (gnt_q == PW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = (state_q == StCalc);
    assign bus.overrun    = overrun_q;

`ifdef JT5205_ARB_MIX_EN
    localparam int unsigned SW = W + PW;

    logic signed [SW-1:0] sum_all;
    logic [W-1:0]         mix_d, mix_q;

    always_comb begin
        sum_all = '0;
        for (int i = 0; i < NCH; i++) begin
            sum_all = sum_all + SW'($signed(dout_q[i*W +: W]));
        end
        // In range when all bits above the W-bit sign agree with it.
        if (sum_all[SW-1:W-1] == '0 || sum_all[SW-1:W-1] == '1) begin
            mix_d = sum_all[W-1:0];
        end else if (sum_all[SW-1]) begin
            mix_d = {1'b1, {(W-1){1'b0}}};
        end else begin
            mix_d = {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mix_q <= '0;
        else     mix_q <= mix_d;
    end

    assign bus.mix = mix_q;
`else
    assign bus.mix = '0;
`endif
endmodule

// File: tb/tb_jt5205_interp_arb.sv
// Bench for jt5205_interp_arb: directed scenarios plus a randomized loss-free run
// checked against a per-channel request list and interpolation model.
module tb_jt5205_interp_arb;
    localparam int NCH = 4;
    localparam int W   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt5205_interp_arb_if #(.NCH(NCH), .W(W)) bus ();

    jt5205_interp_arb #(.NCH(NCH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int ch;
        int val;
        int cyc;
    } req_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lane(input int i);
        logic signed [W-1:0] v;
        v = bus.dout[i*W +: W];
        return int'(v);
    endfunction

    function automatic int mixv();
        logic signed [W-1:0] v;
        v = bus.mix;
        return int'(v);
    endfunction

    function automatic int sat(input int s);
        if (s > 2047) return 2047;
        if (s < -2048) return -2048;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input int val);
        bus.cen_mid[ch]      = 1'b1;
        bus.din[ch*W +: W]   = W'(val);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cen_mid = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Isolated strobe: valid must appear exactly two edges later with the expected value.
    task automatic svc(input int ch, input int val, input int exp, input string tag);
        bus.cen_mid = '0;
        drive(ch, val);
        tick();
        bus.cen_mid = '0;
        check({tag, "_v0"}, int'(bus.dout_valid), 0);
        tick();
        check({tag, "_busy"}, int'(bus.busy), 1);
        check({tag, "_v1"}, int'(bus.dout_valid), 0);
        tick();
        check({tag, "_v2"}, int'(bus.dout_valid), 1 << ch);
        check({tag, "_dout"}, lane(ch), exp);
        repeat (2 * NCH) tick();
    endtask

    initial begin
        int cnt [NCH];
        int d2;
        int expv;
        int cd [NCH];
        int ml [NCH];
        int md [NCH];
        int s, e, exp_mix, k;
        req_t q[$];
        req_t r;

        bus.cen_mid = '0;
        bus.din     = '0;

        // Reset state
        tick();
        tick();
        for (int i = 0; i < NCH; i++) check("rst_dout", lane(i), 0);
        check("rst_valid", int'(bus.dout_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_mix", mixv(), 0);
        rst = 1'b0;
        tick();

        // Single channel
        svc(0, 400, 200, "ch0_a");
        repeat (60) tick();
        svc(0, 800, 600, "ch0_b");

        // Negative rounding toward -inf
        svc(1, -1, -1, "neg_a");
        svc(1, -1, -2, "neg_b");
        svc(1, -2048, -1025, "neg_c");
        svc(1, -2048, -2048, "neg_d");

        // Contention from ptr=0
        do_reset();
        for (int i = 0; i < NCH; i++) drive(i, 100 * (i + 1));
        tick();
        bus.cen_mid = '0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            expv = (t % 2 == 0) ? (1 << (t / 2 - 1)) : 0;
            check("cont_valid", int'(bus.dout_valid), expv);
            if (expv != 0) check("cont_dout", lane(t / 2 - 1), 50 * (t / 2));
        end

        // Overrun on ch2 while ch0/ch1 pending; lasts are 100,200,300,400
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        d2 = 0;
        for (int t = 0; t < 14; t++) begin
            bus.cen_mid = '0;
            if (t == 0) begin
                drive(0, 10);
                drive(1, 20);
            end
            if (t == 1) drive(2, 5);
            if (t == 2) drive(2, 7);
            tick();
            for (int i = 0; i < NCH; i++) cnt[i] += int'(bus.dout_valid[i]);
            if (bus.dout_valid[2]) d2 = lane(2);
        end
        bus.cen_mid = '0;
        check("ovr_cnt0", cnt[0], 1);
        check("ovr_cnt1", cnt[1], 1);
        check("ovr_cnt2", cnt[2], 1);
        check("ovr_dout2", d2, 153);
        check("ovr_dout0", lane(0), 55);
        check("ovr_flags", int'(bus.overrun), 4);

        // Strobe coinciding with its own grant
        do_reset();
        for (int t = 0; t < 9; t++) begin
            bus.cen_mid = '0;
            if (t == 0) drive(3, 100);
            if (t == 1) drive(3, 200);
            tick();
            expv = (t == 2 || t == 4) ? 8 : 0;
            check("same_valid", int'(bus.dout_valid), expv);
            if (t == 2) check("same_old", lane(3), 50);
            if (t == 4) check("same_new", lane(3), 150);
        end
        bus.cen_mid = '0;
        check("same_overrun", int'(bus.overrun), 0);

        // Reset while in CALC
        drive(0, 300);
        tick();
        bus.cen_mid = '0;
        tick();
        check("mid_busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("mid_busy_rst", int'(bus.busy), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            check("mid_valid", int'(bus.dout_valid), 0);
        end
        for (int i = 0; i < NCH; i++) check("mid_dout", lane(i), 0);
        check("mid_mix", mixv(), 0);
        svc(0, 500, 250, "post_rst");

        // Mixer saturation, both signs
        do_reset();
        for (int rep = 0; rep < 4; rep++) begin
            bus.cen_mid = '0;
            for (int i = 0; i < NCH; i++) drive(i, (rep < 2) ? 2047 : -2048);
            tick();
            bus.cen_mid = '0;
            repeat (12) tick();
            if (rep == 1) begin
                check("mix_lane", lane(2), 2046);
`ifdef JT5205_ARB_MIX_EN
                check("mix_pos", mixv(), 2047);
`else
                check("mix_pos", mixv(), 0);
`endif
            end
        end
        check("mix_lane_neg", lane(1), -2048);
`ifdef JT5205_ARB_MIX_EN
        check("mix_neg", mixv(), -2048);
`else
        check("mix_neg", mixv(), 0);
`endif

        // Randomized loss-free traffic against the reference model
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            cd[i] = int'($urandom_range(0, 2 * NCH));
            ml[i] = 0;
            md[i] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            bus.cen_mid = '0;
            for (int i = 0; i < NCH; i++) begin
                if (c < 1900) begin
                    if (cd[i] == 0) begin
                        s = int'($urandom_range(0, 4095)) - 2048;
                        drive(i, s);
                        r.ch = i;
                        r.val = s;
                        r.cyc = c;
                        q.push_back(r);
                        cd[i] = int'($urandom_range(2 * NCH, 3 * NCH)) - 1;
                    end else begin
                        cd[i]--;
                    end
                end
            end
            exp_mix = 0;
            for (int i = 0; i < NCH; i++) exp_mix += md[i];
            exp_mix = sat(exp_mix);
            tick();
`ifdef JT5205_ARB_MIX_EN
            check("rnd_mix", mixv(), exp_mix);
`else
            check("rnd_mix", mixv(), 0);
`endif
            for (int i = 0; i < NCH; i++) begin
                if (bus.dout_valid[i]) begin
                    k = -1;
                    for (int n = 0; n < q.size(); n++) begin
                        if (k < 0 && q[n].ch == i) k = n;
                    end
                    if (k < 0) begin
                        check("rnd_spurious", 1, 0);
                    end else begin
                        r = q[k];
                        q.delete(k);
                        e = (ml[i] >>> 1) + (r.val >>> 1);
                        ml[i] = r.val;
                        md[i] = e;
                        check("rnd_dout", lane(i), e);
                        check("rnd_latency_ok", int'(c - r.cyc <= 2 * NCH + 1), 1);
                    end
                end
            end
        end
        bus.cen_mid = '0;
        check("rnd_drain", q.size(), 0);
        check("rnd_overrun", int'(bus.overrun), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
